pc_unit: RTL and testbench

- Parametrised program-counter unit that owns the architectural PC register. It supersedes the purely combinational next-PC adder.
- Each cycle it selects the next PC from one of six sources: sequential, branch, jump, register, return-stack and exception.
- It honours pipeline stalls and keeps a small return-address stack (RAS) for call/return.
- It sits between fetch and decode. Its `pc` output drives instruction-memory address.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ras_stack.sv | 53 +++++
 rtl/pc_unit.sv | 146 ++++++++++++++
 tb/tb_pc_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: next-PC source select, PC unit FSM states
// and instruction size.
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JREG   = 3'd3,
    PC_RET    = 3'd4,
    PC_EXC    = 3'd5
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack as a circular buffer; a push when full overwrites
// the oldest entry so the newest RAS_DEPTH return addresses are kept.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;

  // r_wp points at the next free slot; the top of stack sits just below it
  assign w_top_idx = r_wp - PTR_W'(1);
  assign dout      = r_mem[w_top_idx];
  assign empty     = (r_cnt == CNT_W'(0));
  assign full      = (r_cnt == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_wp <= r_wp + PTR_W'(1);
      if (!full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      r_wp  <= w_top_idx;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read when the count covers them
  always_ff @(posedge clk) begin
    if (RST && push) begin
      r_mem[r_wp] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: owns the architectural PC, selects the next PC from
// six sources, honours stalls, keeps a return-address stack, halts on misalignment.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0180),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            stall,
  input  logic [2:0]      pc_src,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  input  logic [XLEN-1:0] rs,
  input  logic            call,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            fault
);

  // Low 28 bits of a jump target come from the instruction, the rest from pc+4
  localparam logic [XLEN-1:0] JMP_MASK = XLEN'(28'hFFF_FFFF);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jmp_tgt;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_push;
  logic            w_pop;
  logic            w_misalign;

  assign w_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);
  assign w_br_tgt   = w_pc_plus4 + XLEN'($signed({imm16, 2'b00}));
  assign w_jmp_tgt  = (w_pc_plus4 & ~JMP_MASK) | XLEN'({target26, 2'b00});

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .RST   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_plus4),
    .dout  (w_ras_top),
    .empty (w_ras_empty),
    .full  (w_ras_full)
  );

  // Next-state, next-PC and RAS control
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_misalign  = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (!stall) begin
          case (pc_src)
            PC_BRANCH: w_pc_nxt = w_br_tgt;
            PC_JUMP: begin
              w_pc_nxt = w_jmp_tgt;
              w_push   = call;
            end
            PC_JREG: begin
              w_pc_nxt   = rs;
              w_push     = call;
              w_misalign = (rs[1:0] != 2'b00);
            end
            PC_RET: begin
              if (!w_ras_empty) begin
                w_pc_nxt   = w_ras_top;
                w_pop      = 1'b1;
                w_misalign = (w_ras_top[1:0] != 2'b00);
              end else begin
                w_pc_nxt = w_pc_plus4;
              end
            end
            PC_EXC:  w_pc_nxt = EXC_VECTOR;
            default: w_pc_nxt = w_pc_plus4;
          endcase

          // A bad JREG/RET target aborts the whole transfer, RAS included
          if (w_misalign) begin
            w_pc_nxt    = r_pc;
            w_push      = 1'b0;
            w_pop       = 1'b0;
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        if (!stall && (pc_src == PC_EXC)) begin
          w_pc_nxt    = EXC_VECTOR;
          w_fault_nxt = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;
  assign fault     = r_fault;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: one 32-bit and one 16-bit instance share
// stimulus; a list-based reference model predicts each cycle's outputs.
module tb_pc_unit;

  localparam int    RAS_D = 4;
  localparam longint EXC_V = 64'h180;

  typedef struct {
    longint pc;
    bit     fault;
    bit     empty;
    bit     full;
  } exp_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        stall;
  logic [2:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs;
  logic        call;

  logic [31:0] pc_a, pp4_a;
  logic        empty_a, full_a, fault_a;
  logic [15:0] pc_b, pp4_b;
  logic        empty_b, full_b, fault_b;

  int n_total = 0;
  int n_pass  = 0;

  exp_t qa[$];
  exp_t qb[$];

  longint m_pc    [2];
  bit     m_fault [2];
  bit     m_boot  [2];
  bit     m_halt  [2];
  int     m_cnt   [2];
  longint m_ras   [2][RAS_D];

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h180), .RAS_DEPTH(RAS_D)
  ) dut_a (
    .clk(clk), .RST(RST), .stall(stall), .pc_src(pc_src), .imm16(imm16),
    .target26(target26), .rs(rs), .call(call), .pc(pc_a), .pc_plus4(pp4_a),
    .ras_empty(empty_a), .ras_full(full_a), .fault(fault_a)
  );

  pc_unit #(
    .XLEN(16), .RESET_VECTOR(16'h0), .EXC_VECTOR(16'h180), .RAS_DEPTH(RAS_D)
  ) dut_b (
    .clk(clk), .RST(RST), .stall(stall), .pc_src(pc_src), .imm16(imm16),
    .target26(target26), .rs(rs[15:0]), .call(call), .pc(pc_b), .pc_plus4(pp4_b),
    .ras_empty(empty_b), .ras_full(full_b), .fault(fault_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference model: one architectural step for instance i (0: 32-bit, 1: 16-bit)
  task automatic model_step(input int i, input bit rst_n, input bit stl,
                            input bit [2:0] src, input bit [15:0] imm,
                            input bit [25:0] tgt, input bit [31:0] rsv, input bit cl);
    longint m, pp4, nxt;
    bit     push;
    m = (i == 0) ? 64'hFFFF_FFFF : 64'hFFFF;
    if (!rst_n) begin
      m_pc[i] = 0; m_fault[i] = 0; m_cnt[i] = 0; m_boot[i] = 1; m_halt[i] = 0;
      return;
    end
    if (m_boot[i]) begin
      m_boot[i] = 0;
      return;
    end
    if (m_halt[i]) begin
      if (!stl && src == 3'd5) begin
        m_pc[i] = EXC_V & m; m_halt[i] = 0; m_fault[i] = 0;
      end
      return;
    end
    if (stl) return;
    pp4  = (m_pc[i] + 4) & m;
    nxt  = pp4;
    push = 0;
    case (src)
      3'd1: nxt = (pp4 + longint'($signed(imm)) * 4) & m;
      3'd2: begin nxt = ((pp4 & ~64'hFFF_FFFF) | (longint'(tgt) << 2)) & m; push = cl; end
      3'd3: begin nxt = longint'(rsv) & m; push = cl; end
      3'd4: if (m_cnt[i] > 0) nxt = m_ras[i][m_cnt[i]-1];
      3'd5: nxt = EXC_V & m;
      default: ;
    endcase
    if ((src == 3'd3 || src == 3'd4) && nxt[1:0] != 2'b00) begin
      m_fault[i] = 1; m_halt[i] = 1;
      return;
    end
    if (src == 3'd4 && m_cnt[i] > 0) m_cnt[i]--;
    if (push) begin
      if (m_cnt[i] == RAS_D) begin
        for (int k = 0; k < RAS_D - 1; k++) m_ras[i][k] = m_ras[i][k+1];
        m_ras[i][RAS_D-1] = pp4;
      end else begin
        m_ras[i][m_cnt[i]] = pp4;
        m_cnt[i]++;
      end
    end
    m_pc[i] = nxt;
  endtask

  task automatic drv(input bit r, input bit s, input bit [2:0] src, input bit [15:0] imm,
                     input bit [25:0] tgt, input bit [31:0] rsv, input bit c);
    exp_t e;
    @(negedge clk);
    RST = r; stall = s; pc_src = src; imm16 = imm; target26 = tgt; rs = rsv; call = c;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, s, src, imm, tgt, rsv, c);
      e.pc = m_pc[i]; e.fault = m_fault[i];
      e.empty = (m_cnt[i] == 0); e.full = (m_cnt[i] == RAS_D);
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  // Monitor: compares each instance against its predicted state after every edge
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("pc32", longint'(pc_a), ea.pc);
        chk("pc_plus4_32", longint'(pp4_a), (ea.pc + 4) & 64'hFFFF_FFFF);
        chk("fault32", longint'(fault_a), longint'(ea.fault));
        chk("ras_empty32", longint'(empty_a), longint'(ea.empty));
        chk("ras_full32", longint'(full_a), longint'(ea.full));
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("pc16", longint'(pc_b), eb.pc);
        chk("pc_plus4_16", longint'(pp4_b), (eb.pc + 4) & 64'hFFFF);
        chk("fault16", longint'(fault_b), longint'(eb.fault));
        chk("ras_empty16", longint'(empty_b), longint'(eb.empty));
        chk("ras_full16", longint'(full_b), longint'(eb.full));
      end
    end
  end

  initial begin
    int r;
    bit [2:0]  src;
    bit [31:0] rsv;
    bit        c;
    RST = 1'b0; stall = 1'b0; pc_src = 3'd0; imm16 = '0; target26 = '0; rs = '0; call = 1'b0;

    // Reset, boot cycle, sequential fetch, mid-run reset
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 3'd5, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0);
    // Branch backward/forward and jump
    drv(1, 0, 3'd3, 0, 0, 32'h100, 0);
    drv(1, 0, 3'd1, 16'hFFFE, 0, 0, 0);
    drv(1, 0, 3'd3, 0, 0, 32'h100, 0);
    drv(1, 0, 3'd1, 16'h0003, 0, 0, 0);
    drv(1, 0, 3'd3, 0, 0, 32'h1000_0000, 0);
    drv(1, 0, 3'd2, 0, 26'h40, 0, 0);
    // Stall holds PC regardless of pc_src
    drv(1, 0, 3'd3, 0, 0, 32'h20, 0);
    for (int k = 0; k < 3; k++) drv(1, 1, 3'd1, 16'h0010, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0);
    // RAS call/return, empty return, overflow
    drv(1, 0, 3'd3, 0, 0, 32'h40, 0);
    drv(1, 0, 3'd2, 0, 26'h80, 0, 1);
    drv(1, 0, 3'd4, 0, 0, 0, 0);
    drv(1, 0, 3'd4, 0, 0, 0, 0);
    for (int k = 1; k <= RAS_D + 1; k++) drv(1, 0, 3'd3, 0, 0, 32'h1000 * k, 1);
    for (int k = 0; k <= RAS_D; k++) drv(1, 0, 3'd4, 0, 0, 0, 0);
    // Misaligned register jump, frozen HALT, exception recovery
    drv(1, 0, 3'd3, 0, 0, 32'h1002, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 3'd5, 0, 0, 0, 0);
    drv(1, 0, 3'd5, 0, 0, 0, 0);
    // Wrap-around at the top of the address space
    drv(1, 0, 3'd3, 0, 0, 32'hFFFF_FFFC, 0);
    drv(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 25) src = 3'd0;
      else if (r < 40) src = 3'd1;
      else if (r < 50) src = 3'd2;
      else if (r < 65) src = 3'd3;
      else if (r < 85) src = 3'd4;
      else if (r < 92) src = 3'd5;
      else             src = 3'($urandom_range(6, 7));
      rsv = $urandom() & 32'hFFFF_FFFC;
      c   = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 10) begin
        rsv = rsv | 32'($urandom_range(1, 3));
        c   = 1'b0;
      end
      drv(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 20), src,
          16'($urandom()), 26'($urandom()), rsv, c);
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", longint'(qa.size() + qb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
